// File: rtl/ms_apb_master_pkg.sv
// ---------------------------------------------------------------------------
// ms_apb_master_pkg
//   Shared definitions for the APB initiator: FSM state encoding, the read
//   data value returned on a PREADY timeout, and a helper that sizes the
//   wait-state counter.
// ---------------------------------------------------------------------------
package ms_apb_master_pkg;

  // Two-bit FSM encoding shared by the top and any checker modules.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_RESP   = 2'b11
  } apb_state_e;

  // Same default value the APB slaves return for unmapped reads.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  // Counter width for a timeout limit; a limit of 0 (wait forever) still
  // needs a one-bit counter so the vector is never zero-width.
  function automatic int timeout_cnt_width(input int timeout);
    if (timeout > 0) begin
      return $clog2(timeout + 1);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/ms_apb_master_timeout.sv
// ---------------------------------------------------------------------------
// ms_apb_master_timeout
//   Saturating wait-state counter for the APB ACCESS phase.
//   Ports:
//     clk     in  clock
//     rst_n   in  asynchronous active-low reset
//     clr     in  synchronous clear (start of a new transfer)
//     en      in  count one wait cycle
//     expired out count has reached TIMEOUT (never set when TIMEOUT = 0)
// ---------------------------------------------------------------------------
module ms_apb_master_timeout
  import ms_apb_master_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW    = timeout_cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam bit            ARMED = (TIMEOUT != 0);

  logic [CW-1:0] count_r;

  // Wait-cycle counter: cleared per transfer, saturates at LIMIT, never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else if (clr) begin
      count_r <= {CW{1'b0}};
    end else if (en && ARMED && (count_r != LIMIT)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = ARMED && (count_r == LIMIT);

endmodule

// File: rtl/ms_apb_master.sv
// ---------------------------------------------------------------------------
// ms_apb_master
//   APB initiator. Turns a valid/ready command into one APB transfer
//   (SETUP, ACCESS with PREADY wait states, PSLVERR capture, optional
//   timeout) and returns the result on a valid/ready response port.
//   One transfer outstanding at a time; all outputs are registered.
//   Ports:
//     PCLK, PRESETn                  clock, async active-low reset
//     cmd_valid/cmd_ready            command handshake
//     cmd_write/cmd_addr/cmd_wdata   command payload
//     rsp_valid/rsp_ready            response handshake
//     rsp_rdata/rsp_err              read data (0 for writes), error flag
//     PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB request outputs
//     PRDATA/PREADY/PSLVERR              APB completion inputs
// ---------------------------------------------------------------------------
module ms_apb_master
  import ms_apb_master_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [DW-1:0] PWDATA,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  apb_state_e    state_r,     state_nx;
  logic          cmd_ready_r, cmd_ready_nx;
  logic          psel_r,      psel_nx;
  logic          penable_r,   penable_nx;
  logic          pwrite_r,    pwrite_nx;
  logic [AW-1:0] paddr_r,     paddr_nx;
  logic [DW-1:0] pwdata_r,    pwdata_nx;
  logic          rsp_valid_r, rsp_valid_nx;
  logic [DW-1:0] rsp_rdata_r, rsp_rdata_nx;
  logic          rsp_err_r,   rsp_err_nx;
  logic          cnt_clr_s;
  logic          cnt_en_s;
  logic          cnt_expired_s;

  ms_apb_master_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .clr     (cnt_clr_s),
    .en      (cnt_en_s),
    .expired (cnt_expired_s)
  );

  // State and output registers; reset drops PSEL/PENABLE and any response.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      paddr_r     <= {AW{1'b0}};
      pwdata_r    <= {DW{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DW{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nx;
      cmd_ready_r <= cmd_ready_nx;
      psel_r      <= psel_nx;
      penable_r   <= penable_nx;
      pwrite_r    <= pwrite_nx;
      paddr_r     <= paddr_nx;
      pwdata_r    <= pwdata_nx;
      rsp_valid_r <= rsp_valid_nx;
      rsp_rdata_r <= rsp_rdata_nx;
      rsp_err_r   <= rsp_err_nx;
    end
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_nx     = state_r;
    cmd_ready_nx = cmd_ready_r;
    psel_nx      = psel_r;
    penable_nx   = penable_r;
    pwrite_nx    = pwrite_r;
    paddr_nx     = paddr_r;
    pwdata_nx    = pwdata_r;
    rsp_valid_nx = rsp_valid_r;
    rsp_rdata_nx = rsp_rdata_r;
    rsp_err_nx   = rsp_err_r;
    cnt_clr_s    = 1'b0;
    cnt_en_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          state_nx     = ST_SETUP;
          cmd_ready_nx = 1'b0;
          psel_nx      = 1'b1;
          penable_nx   = 1'b0;
          pwrite_nx    = cmd_write;
          paddr_nx     = cmd_addr;
          pwdata_nx    = cmd_wdata;
          cnt_clr_s    = 1'b1;
        end else begin
          state_nx     = ST_IDLE;
        end
      end

      ST_SETUP: begin
        state_nx   = ST_ACCESS;
        penable_nx = 1'b1;
      end

      ST_ACCESS: begin
        // PREADY is checked first so a completion on the expiry cycle wins.
        if (PREADY) begin
          state_nx     = ST_RESP;
          psel_nx      = 1'b0;
          penable_nx   = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_rdata_nx = pwrite_r ? {DW{1'b0}} : PRDATA;
          rsp_err_nx   = PSLVERR;
        end else if (cnt_expired_s) begin
          state_nx     = ST_RESP;
          psel_nx      = 1'b0;
          penable_nx   = 1'b0;
          rsp_valid_nx = 1'b1;
          rsp_rdata_nx = DW'(TIMEOUT_RDATA);
          rsp_err_nx   = 1'b1;
        end else begin
          cnt_en_s     = 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_nx     = ST_IDLE;
          rsp_valid_nx = 1'b0;
          cmd_ready_nx = 1'b1;
        end else begin
          state_nx     = ST_RESP;
        end
      end

      default: begin
        state_nx     = ST_IDLE;
        cmd_ready_nx = 1'b1;
        psel_nx      = 1'b0;
        penable_nx   = 1'b0;
        rsp_valid_nx = 1'b0;
      end
    endcase
  end

  assign cmd_ready = cmd_ready_r;
  assign PSEL      = psel_r;
  assign PENABLE   = penable_r;
  assign PWRITE    = pwrite_r;
  assign PADDR     = paddr_r;
  assign PWDATA    = pwdata_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule
